// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: ping-pong buffer turning bursty ready/valid pixel frames into gap-free output frames
module pixel_frame_buffer #(
    parameter int PIXELS = 784,
    parameter int DATA_W = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_first,
    output logic              m_last,
    output logic              frame_err,
    output logic [15:0]       frames_out
);
    localparam int AW = $clog2(PIXELS);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    localparam int GL = GAP > 0 ? GAP - 1 : 0;
    localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

    typedef enum logic {WR_FILL, WR_DROP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_GAP} rd_state_e;

    logic [DATA_W-1:0] mem_q [2][PIXELS];
    logic [1:0]        full_q;
    logic              wr_bank_q, rd_bank_q;
    logic [AW-1:0]     wr_cnt_q, rd_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    wr_state_e         wr_state_q;
    rd_state_e         rd_state_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q, m_first_q, m_last_q, frame_err_q;
    logic [15:0]       frames_out_q;
    logic              accept, wr_done, rd_en, rd_done;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        s_ready = rst_n && (wr_state_q == WR_DROP || !full_q[wr_bank_q]);
        accept  = s_valid && s_ready;
        wr_done = accept && wr_state_q == WR_FILL && wr_cnt_q == LAST && s_last;
        rd_en   = (rd_state_q == RD_IDLE && full_q[rd_bank_q]) || rd_state_q == RD_STREAM;
        rd_addr = rd_state_q == RD_STREAM ? rd_cnt_q : '0;
        rd_done = rd_en && rd_addr == LAST;
    end

    always_ff @(posedge clk)
        if (accept && wr_state_q == WR_FILL)
            mem_q[wr_bank_q][wr_cnt_q] <= s_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q  <= WR_FILL;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (accept) begin
                if (wr_state_q == WR_DROP) begin
                    if (s_last)
                        wr_state_q <= WR_FILL;
                end else if (wr_cnt_q == LAST) begin
                    wr_cnt_q <= '0;
                    if (s_last) begin
                        wr_bank_q <= ~wr_bank_q;
                    end else begin
                        frame_err_q <= 1'b1;
                        wr_state_q  <= WR_DROP;
                    end
                end else if (s_last) begin
                    wr_cnt_q    <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
        end else begin
            if (wr_done)
                full_q[wr_bank_q] <= 1'b1;
            if (rd_done)
                full_q[rd_bank_q] <= 1'b0;
        end
    end

    // A bank completing on the same cycle as the final read counts as ready, so full-rate input never opens a hole
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_en) begin
                        rd_state_q <= RD_STREAM;
                        rd_cnt_q   <= AW'(1);
                    end
                end
                RD_STREAM: begin
                    if (rd_done) begin
                        rd_bank_q <= ~rd_bank_q;
                        rd_cnt_q  <= '0;
                        gap_cnt_q <= '0;
                        if (GAP > 0)
                            rd_state_q <= RD_GAP;
                        else if (!(full_q[~rd_bank_q] || wr_done))
                            rd_state_q <= RD_IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (gap_cnt_q == GW'(GL))
                        rd_state_q <= RD_IDLE;
                    else
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frames_out_q <= '0;
        end else begin
            m_valid_q    <= rd_en;
            m_first_q    <= rd_en && rd_addr == '0;
            m_last_q     <= rd_done;
            frames_out_q <= frames_out_q + 16'(rd_done);
            if (rd_en)
                m_data_q <= mem_q[rd_bank_q][rd_addr];
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_first    = m_first_q;
    assign m_last     = m_last_q;
    assign frame_err  = frame_err_q;
    assign frames_out = frames_out_q;
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb_pixel_frame_buffer: directed bench for the ping-pong frame buffer, GAP=0 and GAP=3 instances
module tb_pixel_frame_buffer;
    localparam int PIX = 784;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] s_data = '0, s_data_g = '0;
    logic s_valid = 1'b0, s_last = 1'b0, s_valid_g = 1'b0, s_last_g = 1'b0;
    logic s_ready, m_valid, m_first, m_last, frame_err;
    logic s_ready_g, m_valid_g, m_first_g, m_last_g, frame_err_g;
    logic [7:0] m_data, m_data_g;
    logic [15:0] frames_out, frames_out_g;

    int tests_run = 0, tests_failed = 0, cyc = 0;
    int run = 0, max_run = 0, err_cnt = 0, err_cyc = -1, first_cyc = -1, flag_bad = 0;
    int stall = 0, acc_mark = -1, run_g = 0, max_run_g = 0, last_g_cyc = -1;
    logic [7:0] out_q[$], out_g[$];
    int gap_q[$];

    pixel_frame_buffer #(.PIXELS(PIX), .DATA_W(8), .GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_first(m_first),
        .m_last(m_last), .frame_err(frame_err), .frames_out(frames_out)
    );

    pixel_frame_buffer #(.PIXELS(PIX), .DATA_W(8), .GAP(3)) dut_g (
        .clk(clk), .rst_n(rst_n), .s_data(s_data_g), .s_valid(s_valid_g), .s_last(s_last_g),
        .s_ready(s_ready_g), .m_data(m_data_g), .m_valid(m_valid_g), .m_first(m_first_g),
        .m_last(m_last_g), .frame_err(frame_err_g), .frames_out(frames_out_g)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            if (m_first !== (out_q.size() % PIX == 0) || m_last !== (out_q.size() % PIX == PIX - 1))
                flag_bad++;
            if (m_first === 1'b1 && first_cyc < 0)
                first_cyc = cyc;
            out_q.push_back(m_data);
            run++;
            if (run > max_run)
                max_run = run;
        end else begin
            run = 0;
            if (m_first === 1'b1 || m_last === 1'b1)
                flag_bad++;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (m_valid_g === 1'b1) begin
            if (m_first_g === 1'b1 && last_g_cyc >= 0)
                gap_q.push_back(cyc - last_g_cyc - 1);
            if (m_last_g === 1'b1)
                last_g_cyc = cyc;
            out_g.push_back(m_data_g);
            run_g++;
            if (run_g > max_run_g)
                max_run_g = run_g;
        end else begin
            run_g = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        out_g.delete();
        gap_q.delete();
        run = 0; max_run = 0; err_cnt = 0; err_cyc = -1; first_cyc = -1; flag_bad = 0;
        stall = 0; acc_mark = -1; run_g = 0; max_run_g = 0; last_g_cyc = -1;
    endtask

    task automatic send(input int n, input int base, input int last_at, input int mark, input bit g);
        int i = 0, w = 0;
        logic r;
        while (i < n && w < 5000) begin
            if (g) begin
                s_valid_g = 1'b1; s_data_g = 8'(base + i); s_last_g = (i == last_at);
            end else begin
                s_valid = 1'b1; s_data = 8'(base + i); s_last = (i == last_at);
            end
            @(negedge clk);
            r = g ? s_ready_g : s_ready;
            step();
            if (r === 1'b1) begin
                if (i == mark)
                    acc_mark = cyc;
                i++;
                w = 0;
            end else begin
                w++;
                stall++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0; s_valid_g = 1'b0; s_last_g = 1'b0;
        if (i < n) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout accepted %0d beats, want %0d", i, n);
        end
    endtask

    task automatic wait_out(input int n, input bit g);
        for (int k = 0; k < 6000 && (g ? out_g.size() : out_q.size()) < n; k++)
            step();
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m_valid, m_first, m_last} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags got %b want 000", {m_valid, m_first, m_last});
        end
        tests_run++;
        if (frames_out !== 16'd0 || m_data !== 8'd0) begin
            tests_failed++; $display("FAIL reset_regs got frames=%0d data=%0d want 0 0", frames_out, m_data);
        end
        tests_run++;
        if (s_ready !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready got rdy=%b err=%b want 0 0", s_ready, frame_err);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1 || s_ready_g !== 1'b1) begin
            tests_failed++; $display("FAIL ready_after_reset got %b%b want 11", s_ready, s_ready_g);
        end
        step();
    endtask

    task automatic test_single_frame();
        int bad = 0;
        clear_mon();
        send(PIX, 0, PIX - 1, PIX - 1, 1'b0);
        wait_out(PIX, 1'b0);
        tests_run++;
        if (first_cyc !== acc_mark + 1) begin
            tests_failed++; $display("FAIL single_latency got first at %0d want %0d", first_cyc, acc_mark + 1);
        end
        tests_run++;
        if (out_q.size() !== PIX) begin
            tests_failed++; $display("FAIL single_count got %0d want %0d", out_q.size(), PIX);
        end
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== 8'(i)) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("FAIL single_data got %0d bad pixels want 0", bad);
        end
        tests_run++;
        if (max_run !== PIX || flag_bad !== 0) begin
            tests_failed++; $display("FAIL single_shape got run=%0d flagbad=%0d want %0d 0", max_run, flag_bad, PIX);
        end
        tests_run++;
        if (frames_out !== 16'd1 || err_cnt !== 0) begin
            tests_failed++; $display("FAIL single_frames got frames=%0d err=%0d want 1 0", frames_out, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int bases[3] = '{10, 50, 90};
        clear_mon();
        for (int f = 0; f < 3; f++)
            send(PIX, bases[f], PIX - 1, -1, 1'b0);
        wait_out(3 * PIX, 1'b0);
        tests_run++;
        if (out_q.size() !== 3 * PIX) begin
            tests_failed++; $display("FAIL b2b_count got %0d want %0d", out_q.size(), 3 * PIX);
        end
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== 8'(bases[(i / PIX) % 3] + i % PIX)) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("FAIL b2b_data got %0d bad pixels want 0", bad);
        end
        tests_run++;
        if (max_run !== 3 * PIX || flag_bad !== 0) begin
            tests_failed++; $display("FAIL b2b_contiguous got run=%0d flagbad=%0d want %0d 0", max_run, flag_bad, 3 * PIX);
        end
        tests_run++;
        if (frames_out !== 16'd4 || err_cnt !== 0 || stall !== 0) begin
            tests_failed++;
            $display("FAIL b2b_frames got frames=%0d err=%0d stall=%0d want 4 0 0", frames_out, err_cnt, stall);
        end
    endtask

    task automatic test_short_frame();
        int bad = 0;
        clear_mon();
        send(100, 0, 99, 99, 1'b0);
        repeat (10) step();
        tests_run++;
        if (err_cnt !== 1 || err_cyc !== acc_mark) begin
            tests_failed++; $display("FAIL short_err got cnt=%0d at %0d want 1 at %0d", err_cnt, err_cyc, acc_mark);
        end
        tests_run++;
        if (out_q.size() !== 0) begin
            tests_failed++; $display("FAIL short_discard got %0d pixels out want 0", out_q.size());
        end
        send(PIX, 7, PIX - 1, -1, 1'b0);
        wait_out(PIX, 1'b0);
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== 8'(7 + i)) bad++;
        tests_run++;
        if (out_q.size() !== PIX || bad !== 0) begin
            tests_failed++; $display("FAIL short_next got %0d pixels %0d bad want %0d 0", out_q.size(), bad, PIX);
        end
        tests_run++;
        if (frames_out !== 16'd5 || err_cnt !== 1) begin
            tests_failed++; $display("FAIL short_frames got frames=%0d err=%0d want 5 1", frames_out, err_cnt);
        end
    endtask

    task automatic test_long_frame();
        int bad = 0;
        clear_mon();
        send(PIX + 10, 0, PIX + 9, PIX - 1, 1'b0);
        repeat (10) step();
        tests_run++;
        if (err_cnt !== 1 || err_cyc !== acc_mark) begin
            tests_failed++; $display("FAIL long_err got cnt=%0d at %0d want 1 at %0d", err_cnt, err_cyc, acc_mark);
        end
        tests_run++;
        if (out_q.size() !== 0 || stall !== 0) begin
            tests_failed++; $display("FAIL long_discard got out=%0d stall=%0d want 0 0", out_q.size(), stall);
        end
        send(PIX, 33, PIX - 1, -1, 1'b0);
        wait_out(PIX, 1'b0);
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== 8'(33 + i)) bad++;
        tests_run++;
        if (out_q.size() !== PIX || bad !== 0) begin
            tests_failed++; $display("FAIL long_next got %0d pixels %0d bad want %0d 0", out_q.size(), bad, PIX);
        end
        tests_run++;
        if (frames_out !== 16'd6 || err_cnt !== 1) begin
            tests_failed++; $display("FAIL long_frames got frames=%0d err=%0d want 6 1", frames_out, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send(PIX, 0, PIX - 1, -1, 1'b0);
        wait_out(400, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_valid !== 1'b0 || frames_out !== 16'd0) begin
            tests_failed++; $display("FAIL midreset_out got v=%b frames=%0d want 0 0", m_valid, frames_out);
        end
        tests_run++;
        if (out_q.size() !== 406) begin
            tests_failed++; $display("FAIL midreset_truncate got %0d pixels want 406", out_q.size());
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_release got rdy=%b v=%b data=%0d want 1 0 0", s_ready, m_valid, m_data);
        end
        step();
    endtask

    task automatic test_gap_backpressure();
        int bad = 0, gbad = 0;
        int bases[4] = '{5, 60, 120, 200};
        clear_mon();
        for (int f = 0; f < 4; f++)
            send(PIX, bases[f], PIX - 1, -1, 1'b1);
        wait_out(4 * PIX, 1'b1);
        for (int i = 0; i < out_g.size(); i++)
            if (out_g[i] !== 8'(bases[(i / PIX) % 4] + i % PIX)) bad++;
        tests_run++;
        if (out_g.size() !== 4 * PIX || bad !== 0) begin
            tests_failed++; $display("FAIL gap_data got %0d pixels %0d bad want %0d 0", out_g.size(), bad, 4 * PIX);
        end
        foreach (gap_q[i])
            if (gap_q[i] !== 3) gbad++;
        tests_run++;
        if (gap_q.size() !== 3 || gbad !== 0) begin
            tests_failed++; $display("FAIL gap_idle got %0d gaps %0d wrong want 3 0", gap_q.size(), gbad);
        end
        tests_run++;
        if (stall !== 3) begin
            tests_failed++; $display("FAIL gap_backpressure got %0d stall cycles want 3", stall);
        end
        tests_run++;
        if (frames_out_g !== 16'd4 || max_run_g !== PIX) begin
            tests_failed++; $display("FAIL gap_frames got frames=%0d run=%0d want 4 %0d", frames_out_g, max_run_g, PIX);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
        test_gap_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
